// File: rtl/sample_pipe_pkg.sv
// Shared types and limits for the audio sample retiming pipe.
package sample_pipe_pkg;

   localparam int SAMPLE_W  = 16;
   localparam int MAX_DEPTH = 8;

   typedef logic [SAMPLE_W-1:0] sample_t;

   // Occupancy of one two-entry skid slice
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } stage_state_e;

endpackage

// File: rtl/sample_pipe_stage.sv
// One two-entry skid slice: main register drives downstream, skid register
// catches the sample that arrives in the cycle downstream stalls. Ready is
// decoded purely from held state, so it never follows dnReady_i within a cycle.
module sample_pipe_stage import sample_pipe_pkg::*; #(
   parameter int WIDTH = SAMPLE_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush_i,
   input  logic             upValid_i,
   input  logic [WIDTH-1:0] upData_i,
   output logic             upReady_o,
   output logic             dnValid_o,
   output logic [WIDTH-1:0] dnData_o,
   input  logic             dnReady_i
);

   stage_state_e     state_q, state_d;
   logic [WIDTH-1:0] mainData_q, mainData_d;
   logic [WIDTH-1:0] skidData_q, skidData_d;
   logic             push;
   logic             pop;

   assign upReady_o = (state_q != FULL);
   assign dnValid_o = (state_q != EMPTY);
   assign dnData_o  = mainData_q;
   assign push      = upValid_i & upReady_o;
   assign pop       = dnValid_o & dnReady_i;

   // Next-state and data steering; flush overrides any push or pop
   always_comb begin
      state_d    = state_q;
      mainData_d = mainData_q;
      skidData_d = skidData_q;
      if (flush_i) begin
         state_d    = EMPTY;
         mainData_d = '0;
         skidData_d = '0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (push) begin
                  state_d    = ONE;
                  mainData_d = upData_i;
               end
            end
            ONE: begin
               if (push && !pop) begin
                  state_d    = FULL;
                  skidData_d = upData_i;
               end else if (push && pop) begin
                  mainData_d = upData_i;
               end else if (pop) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  state_d    = ONE;
                  mainData_d = skidData_q;
                  skidData_d = '0;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end
   end

   // State and data registers, cleared immediately on reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= EMPTY;
         mainData_q <= '0;
         skidData_q <= '0;
      end else begin
         state_q    <= state_d;
         mainData_q <= mainData_d;
         skidData_q <= skidData_d;
      end
   end

endmodule

// File: rtl/sample_pipe.sv
// Registered multi-stage sample pipe: DEPTH skid slices in series with a
// running count of samples held anywhere in the chain.
module sample_pipe import sample_pipe_pkg::*; #(
   parameter  int WIDTH = 16,
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(2*DEPTH+1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [CNT_W-1:0] occupancy
);

   generate
      if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_badDepth
         $error("sample_pipe: DEPTH must be in 1..%0d", MAX_DEPTH);
      end
      if (WIDTH < 1 || WIDTH > 32) begin : g_badWidth
         $error("sample_pipe: WIDTH must be in 1..32");
      end
   endgenerate

   logic [DEPTH:0]   validChain;
   logic [DEPTH:0]   readyChain;
   logic [WIDTH-1:0] dataChain [DEPTH+1];
   logic [CNT_W-1:0] occCount_q, occCount_d;
   logic             accept;
   logic             emit;

   assign validChain[0]     = in_valid;
   assign dataChain[0]      = in_data;
   assign in_ready          = readyChain[0];
   assign out_valid         = validChain[DEPTH];
   assign out_data          = dataChain[DEPTH];
   assign readyChain[DEPTH] = out_ready;

   generate
      for (genvar g = 0; g < DEPTH; g++) begin : g_stage
         sample_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk       (clk),
            .reset     (reset),
            .flush_i   (flush),
            .upValid_i (validChain[g]),
            .upData_i  (dataChain[g]),
            .upReady_o (readyChain[g]),
            .dnValid_o (validChain[g+1]),
            .dnData_o  (dataChain[g+1]),
            .dnReady_i (readyChain[g+1])
         );
      end
   endgenerate

   assign accept    = in_valid & in_ready;
   assign emit      = out_valid & out_ready;
   assign occupancy = occCount_q;

   // Occupancy tracks accepts minus emits; flush empties the whole chain
   always_comb begin
      occCount_d = occCount_q;
      if (flush) begin
         occCount_d = '0;
      end else if (accept && !emit) begin
         occCount_d = occCount_q + CNT_W'(1);
      end else if (emit && !accept) begin
         occCount_d = occCount_q - CNT_W'(1);
      end
   end

   // Occupancy register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         occCount_q <= '0;
      end else begin
         occCount_q <= occCount_d;
      end
   end

endmodule
